// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scan_pkg
// Purpose  : Shared definitions for the scan sequencer: FSM state encoding
//            and the dwell/blank counter width.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package scan_pkg;

  // Width of the dwell/blank down-counter.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/next_line.sv
`default_nettype none
// ============================================================================
// Module   : next_line
// Purpose  : Combinational search for the next set mask bit strictly after
//            the current line index, wrapping 3 -> 0. If only the current
//            bit is set, the search wraps back onto the current index.
// Ports    : cur     [1:0] in   current line index
//            mask    [3:0] in   line enable mask
//            nxt     [1:0] out  next selected line index
//            found         out  mask has at least one bit set
//            wrapped       out  the search passed index 3 to reach nxt
// Revision : 1.0  initial release
// ============================================================================
module next_line (
  input  logic [1:0] cur,
  input  logic [3:0] mask,
  output logic [1:0] nxt,
  output logic       found,
  output logic       wrapped
);

  logic [2:0] sum;

  // Scan distances 4 down to 1 so the nearest candidate overwrites the
  // farther ones. Bit 2 of the sum marks that the search passed index 3.
  always_comb begin
    nxt     = cur;
    wrapped = 1'b0;
    found   = |mask;
    sum     = 3'd0;
    for (int k = 4; k >= 1; k--) begin
      sum = {1'b0, cur} + 3'(k);
      if (mask[sum[1:0]]) begin
        nxt     = sum[1:0];
        wrapped = sum[2];
      end
    end
  end

endmodule : next_line
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scan_sequencer
// Purpose  : Steps a downstream 2-to-4 decoder through the lines selected by
//            mask. Each line gets BLANK_CYC cycles with enable low (index
//            already presented) followed by DWELL_CYC cycles with enable
//            high. Continuous (mode=0) or single-pass (mode=1) operation.
// Ports    : clk            in   rising-edge clock
//            rst            in   synchronous active-high reset
//            start          in   start a scan when idle
//            stop           in   abort the scan at the next edge
//            mode           in   0 = continuous, 1 = single pass
//            mask     [3:0] in   bit i set = line i scanned
//            sel_a          out  line index MSB (decoder input A)
//            sel_b          out  line index LSB (decoder input B)
//            enable         out  decoder enable, high only in DWELL
//            busy           out  high in BLANK or DWELL
//            done           out  one-cycle pulse on normal completion
// Revision : 1.0  initial release
// ============================================================================
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_CYC = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [3:0] mask,
  output logic       sel_a,
  output logic       sel_b,
  output logic       enable,
  output logic       busy,
  output logic       done
);

  // Counters count down to zero, so a state lasting N cycles loads N-1.
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD =
    (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             mode_q;

  logic [1:0]       search_from;
  logic [1:0]       nxt;
  logic             found;
  logic             wrapped;

  // From IDLE, searching after index 3 yields the lowest set bit.
  assign search_from = (state == IDLE) ? 2'd3 : idx;

  next_line u_next_line (
    .cur     (search_from),
    .mask    (mask),
    .nxt     (nxt),
    .found   (found),
    .wrapped (wrapped)
  );

  // idx is a flop, so the select lines are registered outputs.
  assign sel_a = idx[1];
  assign sel_b = idx[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= 2'd0;
      mode_q <= 1'b0;
      enable <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            if (!found) begin
              done <= 1'b1;
            end else begin
              idx    <= nxt;
              mode_q <= mode;
              busy   <= 1'b1;
              if (BLANK_CYC == 0) begin
                state  <= DWELL;
                cnt    <= DWELL_LOAD;
                enable <= 1'b1;
              end else begin
                state  <= BLANK;
                cnt    <= BLANK_LOAD;
              end
            end
          end
        end

        BLANK: begin
          if (stop) begin
            state  <= IDLE;
            cnt    <= '0;
            enable <= 1'b0;
            busy   <= 1'b0;
          end else if (cnt == '0) begin
            state  <= DWELL;
            cnt    <= DWELL_LOAD;
            enable <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DWELL: begin
          if (stop) begin
            state  <= IDLE;
            cnt    <= '0;
            enable <= 1'b0;
            busy   <= 1'b0;
          end else if (cnt == '0) begin
            // Line selection: the mask is only consulted here.
            if (!found || (mode_q && wrapped)) begin
              state  <= IDLE;
              cnt    <= '0;
              enable <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              idx <= nxt;
              if (BLANK_CYC == 0) begin
                // Re-enter DWELL directly; enable stays high with no gap.
                cnt <= DWELL_LOAD;
              end else begin
                state  <= BLANK;
                cnt    <= BLANK_LOAD;
                enable <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule : scan_sequencer
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_sequencer
// Purpose  : Self-checking bench for scan_sequencer. Two instances:
//            DWELL_CYC=3/BLANK_CYC=1 and DWELL_CYC=3/BLANK_CYC=0, sharing
//            inputs. Expected output words are queued per cycle and popped
//            one per clock after the rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, mode;
  logic [3:0] mask;

  logic a_sel_a, a_sel_b, a_enable, a_busy, a_done;
  logic z_sel_a, z_sel_b, z_enable, z_busy, z_done;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_CYC(3), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel_a(a_sel_a), .sel_b(a_sel_b), .enable(a_enable), .busy(a_busy), .done(a_done)
  );

  scan_sequencer #(.DWELL_CYC(3), .BLANK_CYC(0)) dut_nb (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel_a(z_sel_a), .sel_b(z_sel_b), .enable(z_enable), .busy(z_busy), .done(z_done)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         use_nb  = 1'b0;
  string      scen    = "init";
  // {sel_dont_care, sel_a, sel_b, enable, busy, done}
  logic [5:0] exp_q[$];

  task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got={sa,sb,en,bz,dn}=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic push(input logic dc, input logic [1:0] ix, input logic en,
                      input logic bz, input logic dn);
    exp_q.push_back({dc, ix, en, bz, dn});
  endtask

  task automatic push_line(input logic [1:0] ix, input int nb, input int nd);
    for (int i = 0; i < nb; i++) push(1'b0, ix, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < nd; i++) push(1'b0, ix, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run(input int n);
    logic [5:0] e;
    logic [4:0] got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = use_nb ? {z_sel_a, z_sel_b, z_enable, z_busy, z_done}
                     : {a_sel_a, a_sel_b, a_enable, a_busy, a_done};
        if (e[5])
          check_val($sformatf("%s@%0d", scen, cyc), {2'b00, got[2:0]}, {2'b00, e[2:0]});
        else
          check_val($sformatf("%s@%0d", scen, cyc), got, e[4:0]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    push(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 4'h0;

    // Reset state, with start held during reset.
    scen = "reset"; start = 1'b1; mask = 4'hF;
    for (int i = 0; i < 3; i++) push(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    run(3);
    start = 1'b0; rst = 1'b0;
    push_idle(2); run(2);

    // Continuous scan over all four lines, then stop in the 2nd DWELL cycle.
    scen = "cont"; do_reset();
    mode = 1'b0; mask = 4'hF; start = 1'b1;
    push_line(2'd0, 1, 3); run(1); start = 1'b0; run(3);
    push_line(2'd1, 1, 3); run(4);
    push_line(2'd2, 1, 3); run(4);
    push_line(2'd3, 1, 3); run(4);
    push_line(2'd0, 1, 3); run(4);
    push(1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    push(1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    push(1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    run(3);
    scen = "stop"; stop = 1'b1;
    push(1'b1, 2'd0, 1'b0, 1'b0, 1'b0); run(1);
    stop = 1'b0;
    push_idle(2); run(2);
    scen = "restart"; start = 1'b1;
    push_line(2'd0, 1, 3); run(1); start = 1'b0; run(3);

    // Single pass over lines 1 and 3; start held and mode flipped mid-scan.
    scen = "single"; do_reset();
    mode = 1'b1; mask = 4'b1010; start = 1'b1;
    push_line(2'd1, 1, 3);
    push_line(2'd3, 1, 3);
    push(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    push_idle(3);
    run(3); mode = 1'b0; run(2); start = 1'b0; run(7);

    // Mask change during DWELL takes effect at the next selection; mask=0
    // at a selection ends the scan with done.
    scen = "maskchg"; do_reset();
    mode = 1'b0; mask = 4'b0001; start = 1'b1;
    push_line(2'd0, 1, 3); run(1); start = 1'b0; mask = 4'b0100; run(3);
    push_line(2'd2, 1, 3); run(2); mask = 4'h0; run(2);
    push(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    push_idle(2); run(3);

    // Single set bit re-enters BLANK for the same line.
    scen = "reenter"; do_reset();
    mode = 1'b0; mask = 4'b0010; start = 1'b1;
    for (int i = 0; i < 3; i++) push_line(2'd1, 1, 3);
    run(1); start = 1'b0; run(11);

    // Start with empty mask: done one cycle later, never busy.
    scen = "empty"; do_reset();
    mask = 4'h0; start = 1'b1;
    push(1'b1, 2'd0, 1'b0, 1'b0, 1'b1); run(1);
    start = 1'b0;
    push_idle(3); run(3);

    // Start and stop together: stop wins.
    scen = "startstop"; do_reset();
    mask = 4'hF; start = 1'b1; stop = 1'b1;
    push_idle(2); run(2);
    start = 1'b0; stop = 1'b0;
    push_idle(1); run(1);

    // Reset during BLANK with start still held.
    scen = "rstblank"; do_reset();
    mode = 1'b0; mask = 4'hF; start = 1'b1;
    push_line(2'd0, 1, 0); run(1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    run(3);
    rst = 1'b0; start = 1'b0;
    push_idle(2); run(2);

    // No blanking: enable continuously high on line 2.
    use_nb = 1'b1;
    scen = "noblank"; do_reset();
    mode = 1'b0; mask = 4'b0100; start = 1'b1;
    for (int i = 0; i < 4; i++) push_line(2'd2, 0, 3);
    run(1); start = 1'b0; run(11);

    // No blanking, single pass on one line.
    scen = "noblank1"; do_reset();
    mode = 1'b1; mask = 4'b0100; start = 1'b1;
    push_line(2'd2, 0, 3);
    push(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    push_idle(2);
    run(1); start = 1'b0; run(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_scan_sequencer
`default_nettype wire

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter DWELL_CYC, default 4: cycles `enable` stays high per selected line; legal range 1..255.
REQ-002 Parameter BLANK_CYC, default 1: cycles `enable` stays low before each line; legal range 0..255 (0 = no blanking).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, using the port names `clk` and `rst`.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  level sampled each cycle; starts a scan when idle.
REQ-007 stop  input  1  aborts the scan at the next edge.
REQ-008 mode  input  1  0 = continuous scan, 1 = single pass.
REQ-009 mask  input  4  bit i set = line i is scanned.
REQ-010 sel_a  output  1  line index MSB; drives downstream 2-to-4 decoder input A.
REQ-011 sel_b  output  1  line index LSB; drives downstream decoder input B.
REQ-012 enable  output  1  drives downstream decoder Enable; high only in DWELL.
REQ-013 busy  output  1  high in BLANK or DWELL.
REQ-014 done  output  1  one-cycle pulse on normal completion.

Function
REQ-015 All outputs SHALL be registered, with no combinational path from input to output.
REQ-016 The FSM SHALL have three states: IDLE, BLANK and DWELL.
REQ-017 In IDLE with start=1, stop=0 and mask!=0, the block SHALL select the lowest set mask bit and enter BLANK, or DWELL if BLANK_CYC=0.
REQ-018 In IDLE with start=1 and mask=0, the block SHALL stay in IDLE and pulse done for one cycle on the next cycle.
REQ-019 Latency: start sampled at edge t SHALL give busy=1 after edge t+1 and enable=1 after edge t+1+BLANK_CYC.
REQ-020 BLANK SHALL last exactly BLANK_CYC cycles with enable=0 and sel_a/sel_b already showing the new line index.
REQ-021 DWELL SHALL last exactly DWELL_CYC cycles with enable=1, and the line index SHALL stay constant for the whole state.
REQ-022 At the end of DWELL, the next line SHALL be the next set mask bit above the current index, wrapping 3->0.
REQ-023 The mask SHALL be sampled only at line selection; changes made during BLANK or DWELL SHALL take effect at the next selection.
REQ-024 When a single set mask bit wraps to itself, the block SHALL re-enter BLANK for the same line.
REQ-025 Mode 1: after the DWELL of the highest set mask bit (where the search would wrap), the block SHALL go to IDLE and pulse done.
REQ-026 Mode 0: the scan SHALL repeat indefinitely, and done SHALL never pulse except as required by REQ-027.
REQ-027 If the mask is 0 at a line selection, the block SHALL go to IDLE, pulse done, and drop enable at the same edge.
REQ-028 If stop=1 in BLANK or DWELL, the block SHALL go to IDLE at that edge with enable=0, busy=0 and no done pulse.
REQ-029 If start and stop are both 1 in IDLE, stop SHALL win and the block SHALL stay in IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 mode SHALL be sampled on start and held for the whole scan.
REQ-032 The internal dwell/blank counter SHALL be 8 bits, and the counter SHALL be reloaded on every state entry.

Reset
REQ-033 When rst=1, the next edge SHALL put the block in IDLE with counter=0, line index=0 and latched mode=0.
REQ-034 During reset, the outputs SHALL be sel_a=0, sel_b=0, enable=0, busy=0 and done=0.
REQ-035 rst SHALL take priority over start and stop.
REQ-036 Reset mid-scan SHALL abort the scan with no done pulse.

Structure
REQ-037 Shared package scan_pkg SHALL hold the state encoding constants (IDLE=2'd0, BLANK=2'd1, DWELL=2'd2) and the counter width constant (8).
REQ-038 A combinational sub-module next_line SHALL compute the next set mask bit after the current index with wrap, plus `found` and `wrapped` flags.
REQ-039 The sel_a/sel_b bit ordering SHALL match the downstream decoder: index {sel_a, sel_b}, where 00 = Y0 and 11 = Y3.

Verification (DWELL_CYC=3, BLANK_CYC=1 unless noted)
REQ-040 mode=0, mask=4'b1111, start pulse -> index sequence 0,1,2,3,0 repeating; each line gives 1 cycle enable=0 then 3 cycles enable=1; no done.
REQ-041 mode=1, mask=4'b1010 -> lines 1 then 3; after line 3's third DWELL cycle: busy=0 and a single done pulse; 8 busy cycles total.
REQ-042 mask=4'b0000, start -> busy never asserts; done=1 exactly one cycle after start.
REQ-043 Scan running, stop asserted in the 2nd DWELL cycle -> the next cycle shows enable=0, busy=0, done=0; a later start restarts from the lowest set bit.
REQ-044 rst asserted mid-BLANK with start=1 held -> all outputs 0 the next cycle; IDLE held while rst=1.
REQ-045 BLANK_CYC=0, mode=0, mask=4'b0100 -> enable stays continuously high on index 2 (re-entry at wrap causes no gap), and index 2 is held.
